cdc_4_phase_rx: RTL and testbench
=================================

# cdc_4_phase_rx

Single-clock responder for the 4-phase req/ack handshake. It synchronizes an asynchronous request from a remote initiator and captures the initiator's data word. It acknowledges each transfer and buffers received words in a small show-ahead FIFO, which drains through a valid/ready stream. It sits in the destination clock domain, opposite a 4-phase transmitter in another domain.

## Interface
- G_STAGES, 2, synchronizer depth for `i_req` (≥2)
- G_WIDTH, 4, data word width
- G_DEPTH, 4, FIFO depth in words (power of 2, ≥2)

- i_clk  in  1  destination clock; all logic on its rising edge
- i_rst  in  1  reset; synchronous, active-high
- i_req  in  1  request from remote initiator, asynchronous to `i_clk`
- i_data  in  G_WIDTH  initiator data; stable from `i_req` rise until `o_ack` seen high
- o_ack  out  1  acknowledge to initiator, registered
- o_busy  out  1  high while a handshake is open (ack high, awaiting req drop)
- o_valid  out  1  FIFO non-empty
- o_data  out  G_WIDTH  FIFO head word
- i_ready  in  1  downstream accepts `o_data` when `o_valid && i_ready`
- o_level  out  $clog2(G_DEPTH)+1  FIFO occupancy, 0..G_DEPTH

## Operation
- `i_req` passes through a G_STAGES flop chain, reset to 0, producing `req_sync`. No other logic samples `i_req`.
- FSM state IDLE (`o_ack`=0): if `req_sync`=1 and FIFO not full, the block:
  - writes `i_data` to FIFO,
  - sets `o_ack`<=1,
  - moves to WAIT_DROP.
- FSM state IDLE, `req_sync`=1 and FIFO full: stall in IDLE with `o_ack` held 0. This is back-pressure to the initiator; no word is lost.
- FSM state WAIT_DROP (`o_ack`=1, `o_busy`=1): when `req_sync`=0, set `o_ack`<=0 and return to IDLE.
- Illegal encoding: go to IDLE with `o_ack`<=0.
- Exactly one FIFO write per req rise; a req held high never writes twice.
- FIFO pop: when `o_valid && i_ready`, the head advances.
- Full check uses current occupancy only. Push while full is never attempted, even if a pop occurs the same cycle; the stalled capture proceeds the next cycle.
- Push and pop in the same cycle leave `o_level` unchanged.
- Read and write pointers wrap modulo G_DEPTH. `o_level` is the count, with no pointer-difference aliasing.
- `o_data` is show-ahead: the head word is valid whenever `o_valid`=1. It holds its value while `o_valid && !i_ready`.

## Timing
- Reset values:
  - `o_ack`=0, `o_busy`=0, `o_valid`=0, `o_level`=0, `o_data`=0.
  - FSM=IDLE; sync chain=0; pointers=0.
- Reset mid-handshake drops `o_ack` and flushes the FIFO. The initiator must itself be reset or observe ack low.
- `i_req` rise → `req_sync` high after G_STAGES edges.
- `req_sync` high in IDLE, not full → on the next edge:
  - `o_ack`=1,
  - `o_busy`=1,
  - `o_level` increments,
  - `o_valid`=1 if the FIFO was empty.
- With the FIFO empty and `i_ready`=1, the word is consumed on the edge after `o_valid` rises.
- `i_req` fall → `req_sync` low after G_STAGES edges → `o_ack`=0 and `o_busy`=0 on the following edge.
- Minimum transfer period, ignoring the initiator's sync: 2·(G_STAGES+1) cycles.

## Configuration
- `CDC_4_PHASE_RX_STALL_CNT_EN` defined:
  - adds output `o_stall_cnt` (16 bits);
  - it counts cycles with FSM=IDLE, `req_sync`=1 and FIFO full;
  - saturates at 16'hFFFF; resets to 0.
- Undefined: port and counter absent; behaviour otherwise identical.

## Test plan
- Single transfer, G_STAGES=2, `i_ready`=1: `i_req`↑ with `i_data`=4'hA at cycle 0 → `o_ack`↑ at cycle 3 with `o_valid`=1, `o_data`=4'hA. `i_req`↓ at cycle 5 → `o_ack`↓ at cycle 8.
- Fill: `i_ready`=0, four handshakes with data 1,2,3,4 → `o_level`=4. A fifth req with data 5 keeps `o_ack`=0. Raise `i_ready` for one cycle → 1 popped, fifth captured next cycle, `o_level`=4, stream order 2,3,4,5.
- Held request: `i_req` held high 20 cycles → exactly one write (`o_level`=1), `o_ack` stays high until `req_sync` drops.
- Simultaneous push/pop: `o_level`=2, capture coincident with pop → `o_level` stays 2; head order preserved.
- Reset at cycle mid-WAIT_DROP with `o_level`=3 → next edge `o_ack`=0, `o_level`=0, `o_valid`=0, `o_data`=0.
- With `CDC_4_PHASE_RX_STALL_CNT_EN`: full FIFO, req held 10 cycles before a pop → `o_stall_cnt`=10.

Source files
------------

// File: rtl/cdc_4_phase_rx_if.sv
// cdc_4_phase_rx_if
//   Bundles the handshake and stream signals of cdc_4_phase_rx.
//   Handshake side : i_req, i_data (from initiator), o_ack, o_busy (to initiator)
//   Stream side    : o_valid, o_data, o_level (to consumer), i_ready (from consumer)
//   modport slave  : the receiver (cdc_4_phase_rx)
//   modport master : the environment (initiator + downstream consumer)
interface cdc_4_phase_rx_if #(
  parameter int G_WIDTH = 4,
  parameter int G_DEPTH = 4
);
  logic                       i_req;
  logic [G_WIDTH-1:0]         i_data;
  logic                       o_ack;
  logic                       o_busy;
  logic                       o_valid;
  logic [G_WIDTH-1:0]         o_data;
  logic                       i_ready;
  logic [$clog2(G_DEPTH):0]   o_level;

  modport slave (
    input  i_req, i_data, i_ready,
    output o_ack, o_busy, o_valid, o_data, o_level
  );

  modport master (
    output i_req, i_data, i_ready,
    input  o_ack, o_busy, o_valid, o_data, o_level
  );
endinterface

// File: rtl/cdc_4_phase_rx.sv
// cdc_4_phase_rx
//   Receiving end of a 4-phase req/ack handshake. The asynchronous request is
//   synchronized through a G_STAGES flop chain; each request rise captures one
//   data word into a show-ahead FIFO which drains through a valid/ready stream.
//   When the FIFO is full the capture stalls with ack held low (back-pressure).
//
//   Ports:
//     i_clk       destination clock, rising edge
//     i_rst       synchronous active-high reset
//     bus         cdc_4_phase_rx_if.slave (i_req, i_data, o_ack, o_busy,
//                 o_valid, o_data, i_ready, o_level)
//     o_stall_cnt 16-bit saturating count of stalled-capture cycles; present
//                 only when CDC_4_PHASE_RX_STALL_CNT_EN is defined
//
//   Parameters: G_STAGES (sync depth, >=2), G_WIDTH (data width),
//               G_DEPTH (FIFO depth, power of 2, >=2)
module cdc_4_phase_rx #(
  parameter int G_STAGES = 2,
  parameter int G_WIDTH  = 4,
  parameter int G_DEPTH  = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
`ifdef CDC_4_PHASE_RX_STALL_CNT_EN
  output logic [15:0]         o_stall_cnt,
`endif
  cdc_4_phase_rx_if.slave     bus
);

  localparam int AW = $clog2(G_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b01,
    ST_WAIT_DROP = 2'b10
  } state_t;

  state_t               state;
  state_t               state_nxt;

  logic [G_STAGES-1:0]  req_ff;
  logic                 req_sync;

  logic [G_WIDTH-1:0]   mem [G_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [LW-1:0]        level;

  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 stall;
  logic                 ack;

  // Request synchronizer: the only logic that samples i_req.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      req_ff <= '0;
    end else begin
      req_ff <= {req_ff[G_STAGES-2:0], bus.i_req};
    end
  end

  assign req_sync = req_ff[G_STAGES-1];

  // FSM: state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE:      state_nxt = push ? ST_WAIT_DROP : ST_IDLE;
      ST_WAIT_DROP: state_nxt = req_sync ? ST_WAIT_DROP : ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs. Full is judged on current occupancy only, so a pop in the
  // same cycle does not let a stalled capture through until the next edge.
  always_comb begin
    ack   = 1'b0;
    push  = 1'b0;
    stall = 1'b0;
    case (state)
      ST_IDLE: begin
        push  = req_sync && !full;
        stall = req_sync && full;
      end
      ST_WAIT_DROP: ack = 1'b1;
      default: ;
    endcase
  end

  // FIFO status
  always_comb begin
    full  = (level == LW'(G_DEPTH));
    empty = (level == '0);
    pop   = !empty && bus.i_ready;
  end

  // Storage is not reset; the head is masked while empty instead.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.i_data;
    end
  end

  // Pointers wrap naturally at G_DEPTH; level is an explicit count so a full
  // FIFO is never confused with an empty one.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

`ifdef CDC_4_PHASE_RX_STALL_CNT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stall_cnt <= '0;
    end else if (stall && (o_stall_cnt != '1)) begin
      o_stall_cnt <= o_stall_cnt + 16'd1;
    end
  end
`else
  logic unused_stall;
  assign unused_stall = stall;
`endif

  // Outputs
  always_comb begin
    bus.o_ack   = ack;
    bus.o_busy  = ack;
    bus.o_valid = !empty;
    bus.o_data  = empty ? '0 : mem[rd_ptr];
    bus.o_level = level;
  end

endmodule

// File: tb/tb_cdc_4_phase_rx.sv
// tb_cdc_4_phase_rx
//   Directed scenarios followed by a randomized initiator/consumer run. After
//   every clock edge all outputs are compared with a reference model built from
//   a request delay line, a "handshake open" flag and a word queue.
module tb_cdc_4_phase_rx;

  localparam int S  = 2;
  localparam int W  = 4;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cdc_4_phase_rx_if #(.G_WIDTH(W), .G_DEPTH(D)) bus ();

`ifdef CDC_4_PHASE_RX_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  cdc_4_phase_rx #(.G_STAGES(S), .G_WIDTH(W), .G_DEPTH(D)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
`ifdef CDC_4_PHASE_RX_STALL_CNT_EN
    .o_stall_cnt (stall_cnt),
`endif
    .bus         (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model
  bit             m_open;
  logic [W-1:0]   m_q[$];
  bit             m_hist[$];
  int             m_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_open = 1'b0;
    m_q.delete();
    m_hist.delete();
    for (int i = 0; i < S; i++) m_hist.push_back(1'b0);
    m_stall = 0;
  endfunction

  task automatic compare_all();
    check("ack",   bus.o_ack,   m_open);
    check("busy",  bus.o_busy,  m_open);
    check("valid", bus.o_valid, m_q.size() != 0);
    check("level", bus.o_level, m_q.size());
    check("data",  bus.o_data,  (m_q.size() != 0) ? m_q[0] : '0);
`ifdef CDC_4_PHASE_RX_STALL_CNT_EN
    check("stall_cnt", stall_cnt, m_stall);
`endif
  endtask

  // Advance the model with the inputs present before the edge, clock, compare.
  task automatic cyc();
    bit sync, full, pop, push;
    if (rst) begin
      model_reset();
    end else begin
      sync = m_hist[S-1];
      full = (m_q.size() == D);
      pop  = (m_q.size() != 0) && bus.i_ready;
      push = !m_open && sync && !full;
      if (!m_open && sync && full && m_stall < 65535) m_stall++;
      if (m_open && !sync) m_open = 1'b0;
      else if (push)       m_open = 1'b1;
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(bus.i_data);
      m_hist.push_front(bus.i_req);
      void'(m_hist.pop_back());
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic wait_ack(input bit lvl, input string tag);
    int n = 0;
    while (bus.o_ack !== lvl && n < 40) begin
      cyc();
      n++;
    end
    check(tag, bus.o_ack, lvl);
  endtask

  task automatic handshake(input logic [W-1:0] d);
    bus.i_req  = 1'b1;
    bus.i_data = d;
    wait_ack(1'b1, "hs_ack_rise");
    bus.i_req  = 1'b0;
    wait_ack(1'b0, "hs_ack_fall");
  endtask

  task automatic drain();
    int n = 0;
    bus.i_ready = 1'b1;
    while (bus.o_valid === 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    bus.i_ready = 1'b0;
    check("drain_empty", bus.o_valid, 1'b0);
  endtask

  logic [W-1:0] fill_order [4] = '{4'h2, 4'h3, 4'h4, 4'h5};

  initial begin
    bus.i_req   = 1'b0;
    bus.i_data  = '0;
    bus.i_ready = 1'b0;
    model_reset();

    // Reset state
    rst = 1'b1;
    cyc();
    cyc();
    check("rst_ack",   bus.o_ack,   1'b0);
    check("rst_busy",  bus.o_busy,  1'b0);
    check("rst_valid", bus.o_valid, 1'b0);
    check("rst_level", bus.o_level, 0);
    check("rst_data",  bus.o_data,  0);
    rst = 1'b0;
    cyc();

    // Single transfer, ready high
    bus.i_ready = 1'b1;
    bus.i_req   = 1'b1;
    bus.i_data  = 4'hA;
    repeat (3) cyc();
    check("t1_ack_rise", bus.o_ack,   1'b1);
    check("t1_valid",    bus.o_valid, 1'b1);
    check("t1_data",     bus.o_data,  4'hA);
    repeat (2) cyc();
    bus.i_req = 1'b0;
    repeat (2) cyc();
    check("t1_ack_hold", bus.o_ack, 1'b1);
    cyc();
    check("t1_ack_fall", bus.o_ack, 1'b0);
    bus.i_ready = 1'b0;

    // Fill, back-pressure, single pop releases stalled capture
    for (int i = 1; i <= 4; i++) handshake(W'(i));
    check("fill_level4", bus.o_level, 4);
    bus.i_req  = 1'b1;
    bus.i_data = 4'h5;
    repeat (10) cyc();
    check("fill_stall_ack", bus.o_ack,   1'b0);
    check("fill_stall_lvl", bus.o_level, 4);
    bus.i_ready = 1'b1;
    cyc();
    bus.i_ready = 1'b0;
    check("fill_pop_lvl", bus.o_level, 3);
    check("fill_pop_ack", bus.o_ack,   1'b0);
    cyc();
    check("fill_cap_ack", bus.o_ack,   1'b1);
    check("fill_cap_lvl", bus.o_level, 4);
    bus.i_req = 1'b0;
    wait_ack(1'b0, "fill_ack_fall");
    for (int i = 0; i < 4; i++) begin
      check("fill_order", bus.o_data, fill_order[i]);
      bus.i_ready = 1'b1;
      cyc();
      bus.i_ready = 1'b0;
    end
    check("fill_empty", bus.o_valid, 1'b0);

    // Held request writes once
    bus.i_req  = 1'b1;
    bus.i_data = 4'h7;
    repeat (20) cyc();
    check("held_level", bus.o_level, 1);
    check("held_ack",   bus.o_ack,   1'b1);
    bus.i_req = 1'b0;
    wait_ack(1'b0, "held_ack_fall");
    drain();

    // Capture coincident with pop
    handshake(4'h3);
    handshake(4'h6);
    check("sim_level_pre", bus.o_level, 2);
    bus.i_req  = 1'b1;
    bus.i_data = 4'hC;
    repeat (S) cyc();
    bus.i_ready = 1'b1;
    cyc();
    bus.i_ready = 1'b0;
    check("sim_level", bus.o_level, 2);
    check("sim_ack",   bus.o_ack,   1'b1);
    check("sim_head",  bus.o_data,  4'h6);
    bus.i_req = 1'b0;
    wait_ack(1'b0, "sim_ack_fall");
    check("sim_head2", bus.o_data, 4'h6);
    bus.i_ready = 1'b1;
    cyc();
    bus.i_ready = 1'b0;
    check("sim_tail", bus.o_data, 4'hC);
    drain();

    // Reset while waiting for request drop, three words stored
    handshake(4'h1);
    handshake(4'h2);
    bus.i_req  = 1'b1;
    bus.i_data = 4'h3;
    wait_ack(1'b1, "mid_ack_rise");
    check("mid_level", bus.o_level, 3);
    rst = 1'b1;
    cyc();
    check("mid_rst_ack",   bus.o_ack,   1'b0);
    check("mid_rst_level", bus.o_level, 0);
    check("mid_rst_valid", bus.o_valid, 1'b0);
    check("mid_rst_data",  bus.o_data,  0);
    rst       = 1'b0;
    bus.i_req = 1'b0;
    repeat (3) cyc();

`ifdef CDC_4_PHASE_RX_STALL_CNT_EN
    // Stall counter: full FIFO, request held 10 cycles past synchronization
    for (int i = 0; i < 4; i++) handshake(W'(i + 8));
    bus.i_req  = 1'b1;
    bus.i_data = 4'hF;
    repeat (S + 10) cyc();
    check("stall_cnt10", stall_cnt, 10);
    bus.i_ready = 1'b1;
    cyc();
    bus.i_ready = 1'b0;
    wait_ack(1'b1, "stall_ack_rise");
    bus.i_req = 1'b0;
    wait_ack(1'b0, "stall_ack_fall");
    drain();
`endif

    // Randomized initiator and consumer, occasional reset
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 249) == 0);
      bus.i_ready = ($urandom_range(0, 2) != 0);
      if (rst) begin
        bus.i_req = 1'b0;
      end else if (!bus.i_req && !bus.o_ack) begin
        bus.i_data = W'($urandom);
        if ($urandom_range(0, 2) == 0) bus.i_req = 1'b1;
      end else if (bus.i_req && bus.o_ack && $urandom_range(0, 1) == 1) begin
        bus.i_req = 1'b0;
      end
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
